img_feeder_121: RTL and testbench
=================================

IMG_FEEDER_121 -- requirements
Module: img_feeder_121

Interface
REQ-001 Parameter N_PIX, default 121, pixels per image.
REQ-002 Parameter PIX_W, default 8, bits per pixel.
REQ-003 Parameter TIMEOUT_CYC, default 4096, WAIT-state watchdog limit in cycles (used only with FEEDER_TIMEOUT_EN).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 pix_data  in  PIX_W  incoming pixel byte.
REQ-007 pix_valid  in  1  pix_data valid.
REQ-008 pix_ready  out  1  feeder accepts a pixel this cycle.
REQ-009 img_source  out  N_PIX*PIX_W  assembled image to network top.
REQ-010 valid_top  out  1  start pulse to network top.
REQ-011 ready_top  in  1  network result-ready pulse.
REQ-012 number  in  32  network prediction, valid while ready_top=1.
REQ-013 res_data  out  32  captured prediction.
REQ-014 res_valid  out  1  res_data valid.
REQ-015 res_ready  in  1  result consumer accepts res_data.
REQ-016 busy  out  1  high unless in LOAD with pix_cnt=0.
REQ-017 timeout  out  1  one-cycle watchdog pulse; constant 0 without FEEDER_TIMEOUT_EN.

Function
REQ-018 FSM states SHALL be LOAD, FIRE, WAIT, RESULT; reset state LOAD.
REQ-019 LOAD: pix_ready=1; each cycle with pix_valid=1 writes pix_data to img_source[PIX_W*pix_cnt +: PIX_W] and increments pix_cnt (0..N_PIX-1).
REQ-020 Acceptance of pixel N_PIX-1 SHALL clear pix_cnt to 0 and move to FIRE next cycle; no wrap past N_PIX-1.
REQ-021 pix_ready SHALL be 0 in FIRE, WAIT, RESULT; pixels presented then are not consumed.
REQ-022 FIRE: valid_top=1 for exactly one cycle, then WAIT; valid_top=0 in all other states.
REQ-023 img_source SHALL be written only in LOAD and held stable from FIRE until the next pixel accept.
REQ-024 WAIT: on ready_top=1, number registered into res_data, res_valid=1 next cycle, state RESULT.
REQ-025 ready_top in LOAD, FIRE or RESULT SHALL be ignored (no capture, no state change).
REQ-026 RESULT: res_data/res_valid held until res_ready=1; on that cycle res_valid clears next cycle and state returns to LOAD.
REQ-027 res_data SHALL retain its last value after handshake until the next capture.
REQ-028 Image-to-image throughput: N_PIX + 2 cycles plus network latency plus result handshake; no overlap of loading and inference.

Reset
REQ-029 rst=0 SHALL immediately clear state to LOAD, pix_cnt to 0, img_source to 0, res_data to 0, valid_top, res_valid, timeout to 0; pix_ready becomes 1 after release.
REQ-030 Reset mid-image or mid-inference SHALL discard partial pixels and any pending result; a ready_top arriving after release is ignored per REQ-025.

Configuration
REQ-031 Macro FEEDER_TIMEOUT_EN defined: a counter runs in WAIT; on reaching TIMEOUT_CYC cycles without ready_top, timeout pulses one cycle, state returns to LOAD, res_valid stays 0; counter clears on entry to WAIT.
REQ-032 FEEDER_TIMEOUT_EN undefined: no counter, timeout tied 0, WAIT held indefinitely.

Verification
REQ-033 Stream pixels 0x00..0x78 back-to-back -> pix_ready drops after 121st accept; img_source[7:0]=0x00, [967:960]=0x78; valid_top high exactly one cycle.
REQ-034 In WAIT drive ready_top=1 with number=7 -> res_valid=1, res_data=7 next cycle; hold res_ready=0 for 5 cycles -> res_data/res_valid stable; res_ready=1 -> LOAD, busy=0.
REQ-035 pix_valid toggled every other cycle -> exactly 121 accepts, valid_top after the 121st, pixels offered after it not consumed.
REQ-036 rst=0 after 60 pixels, then full 121-pixel image -> img_source holds only new image, one valid_top.
REQ-037 ready_top pulse in LOAD (pix_cnt=30) -> no res_valid, pix_cnt continues to 31.
REQ-038 With FEEDER_TIMEOUT_EN, TIMEOUT_CYC=16, no ready_top -> timeout pulse 16 cycles after WAIT entry, state LOAD, res_valid=0.

Source files
------------

// File: rtl/img_feeder_121.sv
// rtl/img_feeder_121.sv - pixel stream to image buffer feeder with result capture
//
// Collects N_PIX pixels of PIX_W bits from a valid/ready pixel stream into a
// flat image register, fires a one-cycle start pulse to the network top,
// waits for the network's result-ready pulse, and holds the captured
// prediction until the result consumer takes it.
//
// Optional feature macro: FEEDER_TIMEOUT_EN
//   defined   - watchdog counts WAIT cycles; after TIMEOUT_CYC cycles without
//               ready_top it pulses timeout and returns to LOAD.
//   undefined - no watchdog, timeout tied low, WAIT held indefinitely.
//
// Ports:
//   clk        in   clock, all state changes on its rising edge
//   rst        in   asynchronous active-low reset
//   pix_data   in   incoming pixel
//   pix_valid  in   pix_data valid
//   pix_ready  out  feeder accepts a pixel this cycle (LOAD only)
//   img_source out  assembled image, pixel k at [PIX_W*k +: PIX_W]
//   valid_top  out  one-cycle start pulse to network top
//   ready_top  in   network result-ready pulse (honoured in WAIT only)
//   number     in   network prediction, valid while ready_top=1
//   res_data   out  captured prediction, retained until the next capture
//   res_valid  out  res_data valid
//   res_ready  in   result consumer accepts res_data
//   busy       out  high unless idle in LOAD with no pixels collected
//   timeout    out  one-cycle watchdog pulse

module img_feeder_121 #(
    parameter int N_PIX       = 121,
    parameter int PIX_W       = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIX_W-1:0]       pix_data,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [N_PIX*PIX_W-1:0] img_source,
    output logic                   valid_top,
    input  logic                   ready_top,
    input  logic [31:0]            number,
    output logic [31:0]            res_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   busy,
    output logic                   timeout
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_FIRE   = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam int CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_PIX - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         pix_cnt_q, pix_cnt_d;
    logic [N_PIX*PIX_W-1:0]   img_q, img_d;
    logic [31:0]              res_data_q, res_data_d;
    logic                     res_valid_q, res_valid_d;

`ifdef FEEDER_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                     timeout_q, timeout_d;
`else
    logic                     unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        img_d       = img_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
`ifdef FEEDER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            S_LOAD: begin
                if (pix_valid) begin
                    // Decoded write keeps the image slice select static.
                    for (int i = 0; i < N_PIX; i++) begin
                        if (pix_cnt_q == CNT_W'(i)) begin
                            img_d[i*PIX_W +: PIX_W] = pix_data;
                        end
                    end
                    if (pix_cnt_q == LAST_PIX) begin
                        pix_cnt_d = '0;
                        state_d   = S_FIRE;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            S_FIRE: begin
                state_d = S_WAIT;
`ifdef FEEDER_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (ready_top) begin
                    res_data_d  = number;
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end
`ifdef FEEDER_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_LOAD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            pix_cnt_q   <= '0;
            img_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            img_q       <= img_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
`ifdef FEEDER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign pix_ready  = (state_q == S_LOAD);
    assign valid_top  = (state_q == S_FIRE);
    assign busy       = !((state_q == S_LOAD) && (pix_cnt_q == '0));
    assign img_source = img_q;
    assign res_data   = res_data_q;
    assign res_valid  = res_valid_q;
`ifdef FEEDER_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_img_feeder_121.sv
// tb/tb_img_feeder_121.sv - directed self-checking bench for img_feeder_121

module tb_img_feeder_121;

    localparam int N   = 121;
    localparam int W   = 8;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   pix_data;
    logic           pix_valid;
    logic           pix_ready;
    logic [N*W-1:0] img_source;
    logic           valid_top;
    logic           ready_top;
    logic [31:0]    number;
    logic [31:0]    res_data;
    logic           res_valid;
    logic           res_ready;
    logic           busy;
    logic           timeout;

    int checks   = 0;
    int failures = 0;
    logic [N*W-1:0] exp_img;

    img_feeder_121 #(.N_PIX(N), .PIX_W(W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .img_source(img_source), .valid_top(valid_top),
        .ready_top(ready_top), .number(number),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pv(input int mode, input int i);
        case (mode)
            0:       return 8'(i);
            1:       return 8'(i * 3 + 5);
            2:       return 8'(i ^ 90);
            3:       return 8'(i + 192);
            default: return 8'(255 - i);
        endcase
    endfunction

    // Drives `count` back-to-back pixels; assumes the feeder is in LOAD.
    task automatic feed(input int mode, input int first, input int count);
        for (int k = 0; k < count; k++) begin
            pix_valid = 1'b1;
            pix_data  = pv(mode, first + k);
            exp_img[(first + k) * W +: W] = pix_data;
            step();
        end
        pix_valid = 1'b0;
    endtask

    // From WAIT: answer with a result and complete the handshake.
    task automatic drain(input logic [31:0] num);
        ready_top = 1'b1;
        number    = num;
        step();
        ready_top = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        checks++; if (img_source !== '0) begin failures++; $display("FAIL rst_img: got %h", img_source[63:0]); end
        checks++; if (res_data !== 32'd0 || res_valid !== 1'b0) begin failures++; $display("FAIL rst_res: got data=%h valid=%b, want 0/0", res_data, res_valid); end
        checks++; if (valid_top !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL rst_pulses: got valid_top=%b timeout=%b, want 0/0", valid_top, timeout); end
        rst = 1'b1;
        step();
        checks++; if (pix_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rst_release: got pix_ready=%b busy=%b, want 1/0", pix_ready, busy); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            pix_valid = 1'b1;
            pix_data  = pv(0, i);
            exp_img[i * W +: W] = pix_data;
            if (pix_ready !== 1'b1 || valid_top !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_accept: %0d bad cycles, want 0", bad); end
        checks++; if (pix_ready !== 1'b0 || valid_top !== 1'b1) begin failures++; $display("FAIL b2b_fire: got pix_ready=%b valid_top=%b, want 0/1", pix_ready, valid_top); end
        pix_data = 8'hAA;
        step();
        pix_valid = 1'b0;
        checks++; if (valid_top !== 1'b0 || pix_ready !== 1'b0) begin failures++; $display("FAIL b2b_wait: got valid_top=%b pix_ready=%b, want 0/0", valid_top, pix_ready); end
        checks++; if (img_source[7:0] !== 8'h00 || img_source[967:960] !== 8'h78) begin failures++; $display("FAIL b2b_ends: got first=%h last=%h, want 00/78", img_source[7:0], img_source[967:960]); end
        checks++; if (img_source !== exp_img) begin failures++; $display("FAIL b2b_image: got %h want %h", img_source[63:0], exp_img[63:0]); end
    endtask

    task automatic test_result_handshake();
        int bad = 0;
        ready_top = 1'b1;
        number    = 32'd7;
        step();
        ready_top = 1'b0;
        number    = 32'hDEADBEEF;
        checks++; if (res_valid !== 1'b1 || res_data !== 32'd7) begin failures++; $display("FAIL hs_capture: got valid=%b data=%h, want 1/7", res_valid, res_data); end
        for (int i = 0; i < 5; i++) begin
            step();
            if (res_valid !== 1'b1 || res_data !== 32'd7 || busy !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL hs_hold: %0d unstable cycles, want 0", bad); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || pix_ready !== 1'b1) begin failures++; $display("FAIL hs_done: got valid=%b busy=%b pix_ready=%b, want 0/0/1", res_valid, busy, pix_ready); end
        checks++; if (res_data !== 32'd7) begin failures++; $display("FAIL hs_retain: got %h want 7", res_data); end
    endtask

    task automatic test_toggle_valid();
        int acc = 0;
        int bad = 0;
        for (int cyc = 0; cyc < 400 && acc < N; cyc++) begin
            if (cyc % 2 == 0) begin
                pix_valid = 1'b1;
                pix_data  = pv(1, acc);
            end else begin
                pix_valid = 1'b0;
                pix_data  = 8'hEE;
            end
            if (valid_top !== 1'b0) bad++;
            if (pix_valid && pix_ready) begin
                exp_img[acc * W +: W] = pix_data;
                acc++;
            end
            step();
        end
        pix_valid = 1'b0;
        checks++; if (acc != N || bad != 0) begin failures++; $display("FAIL tog_count: accepts=%0d early_fire=%0d, want %0d/0", acc, bad, N); end
        checks++; if (valid_top !== 1'b1) begin failures++; $display("FAIL tog_fire: got valid_top=%b want 1", valid_top); end
        pix_valid = 1'b1;
        pix_data  = 8'h33;
        ready_top = 1'b1;
        number    = 32'd99;
        step();
        ready_top = 1'b0;
        checks++; if (res_valid !== 1'b0 || pix_ready !== 1'b0 || valid_top !== 1'b0) begin failures++; $display("FAIL tog_fire_ignore: got res_valid=%b pix_ready=%b valid_top=%b, want 0/0/0", res_valid, pix_ready, valid_top); end
        step();
        step();
        pix_valid = 1'b0;
        checks++; if (img_source !== exp_img) begin failures++; $display("FAIL tog_image: got %h want %h", img_source[63:0], exp_img[63:0]); end
        drain(32'd1);
    endtask

    task automatic test_ready_top_in_load();
        feed(2, 0, 30);
        ready_top = 1'b1;
        number    = 32'd55;
        step();
        ready_top = 1'b0;
        checks++; if (res_valid !== 1'b0 || busy !== 1'b1 || pix_ready !== 1'b1) begin failures++; $display("FAIL load_rt_ignore: got res_valid=%b busy=%b pix_ready=%b, want 0/1/1", res_valid, busy, pix_ready); end
        feed(2, 30, 90);
        checks++; if (valid_top !== 1'b0 || pix_ready !== 1'b1) begin failures++; $display("FAIL load_rt_count: got valid_top=%b pix_ready=%b after 120, want 0/1", valid_top, pix_ready); end
        feed(2, 120, 1);
        checks++; if (valid_top !== 1'b1) begin failures++; $display("FAIL load_rt_fire: got valid_top=%b want 1", valid_top); end
        step();
        checks++; if (img_source !== exp_img) begin failures++; $display("FAIL load_rt_image: got %h want %h", img_source[63:0], exp_img[63:0]); end
        drain(32'd2);
    endtask

    task automatic test_reset_mid();
        int vt = 0;
        feed(3, 0, 60);
        rst = 1'b0;
        #1;
        checks++; if (img_source !== '0 || busy !== 1'b0) begin failures++; $display("FAIL mid_async: got img=%h busy=%b, want 0/0", img_source[63:0], busy); end
        step();
        rst = 1'b1;
        step();
        exp_img = '0;
        for (int i = 0; i < N; i++) begin
            pix_valid = 1'b1;
            pix_data  = pv(4, i);
            exp_img[i * W +: W] = pix_data;
            if (valid_top === 1'b1) vt++;
            step();
        end
        pix_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (valid_top === 1'b1) vt++;
            step();
        end
        checks++; if (vt != 1) begin failures++; $display("FAIL mid_fire_count: got %0d pulses want 1", vt); end
        checks++; if (img_source !== exp_img) begin failures++; $display("FAIL mid_image: got %h want %h", img_source[63:0], exp_img[63:0]); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        ready_top = 1'b1;
        number    = 32'd77;
        step();
        ready_top = 1'b0;
        checks++; if (res_valid !== 1'b0 || res_data !== 32'd0 || pix_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL mid_inf_reset: got valid=%b data=%h pix_ready=%b busy=%b, want 0/0/1/0", res_valid, res_data, pix_ready, busy); end
    endtask

    task automatic test_wait_timeout();
        feed(0, 0, N);
        step();
`ifdef FEEDER_TIMEOUT_EN
        begin
            int k = 0;
            while (timeout !== 1'b1 && k < 100) begin
                step();
                k++;
            end
            checks++; if (k != TMO) begin failures++; $display("FAIL tmo_latency: got %0d cycles want %0d", k, TMO); end
            checks++; if (pix_ready !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL tmo_state: got pix_ready=%b res_valid=%b, want 1/0", pix_ready, res_valid); end
            step();
            checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL tmo_pulse: got %b want 0", timeout); end
        end
`else
        begin
            int bad = 0;
            for (int i = 0; i < 3 * TMO; i++) begin
                if (timeout !== 1'b0 || pix_ready !== 1'b0 || res_valid !== 1'b0) bad++;
                step();
            end
            checks++; if (bad != 0) begin failures++; $display("FAIL wait_hold: %0d bad cycles want 0", bad); end
            drain(32'd3);
            checks++; if (res_data !== 32'd3 || pix_ready !== 1'b1) begin failures++; $display("FAIL wait_late_result: got data=%h pix_ready=%b, want 3/1", res_data, pix_ready); end
        end
`endif
    endtask

    initial begin
        rst       = 1'b0;
        pix_data  = '0;
        pix_valid = 1'b0;
        ready_top = 1'b0;
        number    = '0;
        res_ready = 1'b0;
        exp_img   = '0;
        test_reset();
        test_back_to_back();
        test_result_handshake();
        test_toggle_valid();
        test_ready_top_in_load();
        test_reset_mid();
        test_wait_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
